// File: rtl/mem_responder_pkg.sv
// Shared definitions for the MAR/MDR memory responder: state encoding and
// default geometry, reused by the datapath and control blocks.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;

    // Wait counter start value; a zero wait count never loads the counter.
    function automatic logic [3:0] wait_load(input int unsigned cycles);
        return (cycles > 0) ? 4'(cycles - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM, one write port and a registered read.
// Kept apart from the control FSM so a vendor macro can replace it.
module mem_ram_sp #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    // Storage write and registered read; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts Read/Write from MAR/MDR, inserts wait
// states, and completes each access with a one-cycle Done pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  LoadEn,
    input  logic [ADDR_WIDTH-1:0] LoadAddr,
    input  logic [DATA_WIDTH-1:0] LoadData,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  Done,
    output logic                  Busy,
    output logic                  ReqErr
);

    localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    op_wr_q;
    logic                    acc_ph_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   mdatain_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    reqerr_q;

    logic                    ram_we_s;
    logic [ADDR_WIDTH-1:0]   ram_addr_s;
    logic [DATA_WIDTH-1:0]   ram_wdata_s;
    logic [DATA_WIDTH-1:0]   ram_rdata_s;

    // RAM port mux: preload in IDLE, otherwise the latched transaction.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = addr_q;
        ram_wdata_s = wdata_q;
        if (clear) begin
            ram_we_s = 1'b0;
        end else if ((state_q == ST_IDLE) && LoadEn) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = LoadAddr;
            ram_wdata_s = LoadData;
        end else if ((state_q == ST_ACCESS) && !acc_ph_q && op_wr_q) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    mem_ram_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            acc_ph_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mdatain_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            reqerr_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            reqerr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (LoadEn) begin
                        busy_q <= 1'b0;
                    end else if (Read && Write) begin
                        reqerr_q <= 1'b1;
                    end else if (Read || Write) begin
                        addr_q  <= Address;
                        wdata_q <= WriteData;
                        op_wr_q <= Write;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                // First phase issues the RAM op, second captures read data.
                ST_ACCESS: begin
                    if (!acc_ph_q) begin
                        acc_ph_q <= 1'b1;
                    end else begin
                        acc_ph_q <= 1'b0;
                        if (!op_wr_q) begin
                            mdatain_q <= ram_rdata_s;
                        end
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Mdatain = mdatain_q;
    assign Done    = done_q;
    assign Busy    = busy_q;
    assign ReqErr  = reqerr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: transactions queued at issue, a
// negedge monitor retires them on Done against a word-array memory model.
module tb_mem_responder;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int WC = 1;

    logic          clk = 1'b0;
    logic          clear;
    logic          rd, wr, ld;
    logic [AW-1:0] addr, ldaddr;
    logic [DW-1:0] wdata, lddata, mdat;
    logic          done, busy, reqerr;

    logic          rd0, wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, mdat0;
    logic          done0, busy0, reqerr0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
        .Clock(clk), .clear(clear), .Read(rd), .Write(wr), .Address(addr),
        .WriteData(wdata), .LoadEn(ld), .LoadAddr(ldaddr), .LoadData(lddata),
        .Mdatain(mdat), .Done(done), .Busy(busy), .ReqErr(reqerr)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
        .Clock(clk), .clear(clear), .Read(rd0), .Write(wr0), .Address(addr0),
        .WriteData(wdata0), .LoadEn(1'b0), .LoadAddr(9'd0), .LoadData(32'd0),
        .Mdatain(mdat0), .Done(done0), .Busy(busy0), .ReqErr(reqerr0)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            acc;
        int            due;
    } txn_t;

    txn_t          q[$];
    logic [DW-1:0] mem_m [0:(1 << AW) - 1];
    logic [DW-1:0] exp_mdat;
    bit            exp_reqerr = 1'b0;
    bit            chk_on = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: Busy window, ReqErr, Done timing and Mdatain every cycle.
    always @(negedge clk) begin
        txn_t t;
        bit   bexp;
        if (chk_on) begin
            bexp = (q.size() > 0) && (cyc >= q[0].acc) && (cyc <= q[0].due);
            check("busy", busy, bexp);
            check("reqerr", reqerr, exp_reqerr);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    t = q.pop_front();
                    check("done_cycle", cyc, t.due);
                    if (t.wr) mem_m[t.a] = t.d;
                    else      exp_mdat = mem_m[t.a];
                end
            end
            check("mdatain", mdat, exp_mdat);
        end
    end

    task automatic wait_idle();
        int b = 0;
        while (q.size() > 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (q.size() > 0) begin
            check("timeout", 1, 0);
            q.delete();
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld = 1'b1; ldaddr = a; lddata = d;
        @(posedge clk); #1;
        mem_m[a] = d;
        ld = 1'b0;
    endtask

    // Issue one request; optionally scramble every input while busy.
    task automatic req(input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit garble);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        q.push_back('{w, a, d, cyc, cyc + WC + 2});
        for (int k = 0; k <= WC + 1; k++) begin
            @(negedge clk);
            if (garble) begin
                rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
                addr = AW'($urandom); wdata = $urandom;
                ld = 1'($urandom_range(0, 1)); ldaddr = AW'($urandom_range(0, 15)); lddata = $urandom;
            end else begin
                rd = 1'b0; wr = 1'b0;
            end
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; ld = 1'b0;
        wait_idle();
    endtask

    task automatic both_high();
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = AW'($urandom_range(0, 15)); wdata = $urandom;
        @(posedge clk); #1;
        exp_reqerr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        exp_reqerr = 1'b0;
    endtask

    task automatic req0(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd);
        int n0, b, nbusy;
        @(negedge clk);
        rd0 = !w; wr0 = w; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        n0 = cyc; b = 0; nbusy = 0;
        rd0 = 1'b0; wr0 = 1'b0;
        do begin
            @(negedge clk);
            if (busy0) nbusy++;
            b++;
        end while (!done0 && b < 10);
        check("w0_done_cycle", cyc, n0 + 2);
        check("w0_busy_cycles", nbusy, 3);
        if (!w) check("w0_mdatain", mdat0, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        int            op;
        clear = 1'b1; rd = 1'b0; wr = 1'b0; ld = 1'b0;
        addr = '0; wdata = '0; ldaddr = '0; lddata = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        exp_mdat = '0;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;
        chk_on = 1'b1;
        check("reset_mdatain0", mdat0, 0);
        check("reset_busy0", busy0, 0);

        for (int i = 0; i < 16; i++) load(AW'(i), $urandom);

        // Preload then read back: 4-cycle Busy window, data held afterwards.
        load(9'd4, 32'h4);
        load(9'd5, 32'h5);
        req(1'b1, 1'b0, 9'd5, 32'd0, 1'b0);
        repeat (3) @(negedge clk);

        // Write then read the same address back to back.
        req(1'b0, 1'b1, 9'd9, 32'h1891_2000, 1'b0);
        req(1'b1, 1'b0, 9'd9, 32'd0, 1'b0);

        both_high();
        req(1'b1, 1'b0, 9'd4, 32'd0, 1'b1);

        // Abort a write in its wait state with clear.
        load(9'd3, 32'hA);
        @(negedge clk);
        wr = 1'b1; addr = 9'd3; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        q.push_back('{1'b1, 9'd3, 32'hDEAD_BEEF, cyc, cyc + WC + 2});
        @(negedge clk);
        wr = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        q.delete();
        exp_mdat = '0;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        req(1'b1, 1'b0, 9'd3, 32'd0, 1'b0);

        // Preload wins over a same-cycle read, which is taken next cycle.
        @(negedge clk);
        ld = 1'b1; ldaddr = 9'd7; lddata = 32'h8; rd = 1'b1; addr = 9'd7;
        @(posedge clk); #1;
        mem_m[7] = 32'h8;
        ld = 1'b0;
        req(1'b1, 1'b0, 9'd7, 32'd0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            v  = $urandom;
            if (op < 2)      load(AW'($urandom_range(0, 15)), v);
            else if (op < 6) req(1'b1, 1'b0, AW'($urandom_range(0, 15)), v, 1'($urandom_range(0, 1)));
            else if (op < 9) req(1'b0, 1'b1, AW'($urandom_range(0, 15)), v, 1'($urandom_range(0, 1)));
            else             both_high();
        end

        req0(1'b1, 9'd9, 32'h1891_2000, 32'd0);
        req0(1'b0, 9'd9, 32'd0, 32'h1891_2000);

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR memory interface.
- Receives Read/Write strobes with an address from MAR and write data from MDR.
- Returns read data on Mdatain, which feeds MDR under Read/MDRin, and completes each access with a one-cycle Done pulse after a fixed wait-state count.
- Replaces bench-driven Mdatain in system-level simulation; synchronous 2**ADDR_WIDTH x DATA_WIDTH RAM with a side preload port.

Parameters:
- ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- WAIT_CYCLES, 1, wait states inserted before the access cycle; legal range 0..15.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- Read  in  1  read request, sampled in IDLE.
- Write  in  1  write request, sampled in IDLE.
- Address  in  ADDR_WIDTH  word address, from MAR.
- WriteData  in  DATA_WIDTH  write data, from MDR.
- LoadEn  in  1  preload strobe; acts in IDLE only.
- LoadAddr  in  ADDR_WIDTH  preload address.
- LoadData  in  DATA_WIDTH  preload data.
- Mdatain  out  DATA_WIDTH  read data to MDR; holds the last completed read.
- Done  out  1  one-cycle completion pulse.
- Busy  out  1  high from acceptance until the cycle Done is high, inclusive.
- ReqErr  out  1  one-cycle pulse on an illegal request.

Behaviour:
- One clock domain (Clock). Reset is synchronous and active-high (clear).
- Reset values: state IDLE; Mdatain = 0; Done = 0; Busy = 0; ReqErr = 0; wait counter = 0.
- clear does not initialise the RAM array. Contents survive clear.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Read xor Write high → latch Address, WriteData and the op; Busy = 1 next cycle.
  - Go to WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES-1), else go to ACCESS.
- WAIT: counter decrements each cycle. At 0 → ACCESS.
- ACCESS:
  - Read: Mdatain <= mem[latched addr].
  - Write: mem[latched addr] <= latched data; Mdatain unchanged.
  - → DONE.
- DONE: Done = 1 and Busy = 1 for exactly this cycle → IDLE.
- Latency: a request sampled at edge N gives Done high in the cycle after edge N+WAIT_CYCLES+2. Read data is valid on Mdatain in that same cycle and stays stable until the next read's ACCESS.
- Read and Write both high in IDLE: no access, no state change, ReqErr = 1 for the following cycle.
- Read/Write while Busy: ignored. No queueing. Latched address and data are unaffected by input changes.
- A request held high across DONE is re-accepted in the next IDLE cycle. Requesters must deassert on Done.
- Write then Read to the same address, back-to-back: the read returns the new value.
- LoadEn in IDLE:
  - mem[LoadAddr] <= LoadData at the edge.
  - If Read/Write is also high the same cycle, LoadEn has priority and the request is not accepted that cycle; it is accepted the next cycle if still high.
- LoadEn outside IDLE: ignored.
- clear mid-operation: return to IDLE. A pending write is dropped if not yet at ACCESS. Done is not asserted. Mdatain = 0.
- Address wrap: none needed; the address is the full index width.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, DONE=2'd3) and defaults for ADDR_WIDTH and DATA_WIDTH, reused by the datapath/control.
- One sub-module, mem_ram_sp: single-port synchronous RAM with one write port and a registered read.
  - The write port is muxed between preload and ACCESS.
  - Keeps the FSM separate from the storage so the RAM can be swapped for a vendor macro.

Test Plan:
1. Preload mem[4]=32'h4, mem[5]=32'h5; Read Address=5, WAIT_CYCLES=1 → Busy 4 cycles; Done 1 cycle; Mdatain=32'h5 in the Done cycle and held afterwards.
2. Write Address=9, WriteData=32'h18912000; on Done issue Read 9 → Mdatain=32'h18912000. Also a WAIT_CYCLES=0 build: Done 2 cycles after acceptance.
3. Read and Write both high in IDLE → ReqErr pulses once; Busy stays 0; mem and Mdatain unchanged.
4. Read accepted, Address toggled 4→5 and Read re-pulsed during WAIT → single Done; data from address 4; no second transaction.
5. clear asserted in WAIT of a Write to address 3 (old value 32'hA) → next cycle IDLE, Busy=0, Done never pulses, Mdatain=0, later Read 3 returns 32'hA.
6. LoadEn with Read the same cycle (LoadAddr=7, LoadData=32'h8, Read Address=7) → load applies and Read is accepted next cycle; Mdatain=32'h8 at Done.
